// File: rtl/snake_dir_ctrl.sv
// Direction controller for the snake core: synchronizes and debounces four
// push-buttons, queues one legal turn and commits it on the next body move.
module snake_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [1:0]  DIR_INIT        = 2'b00
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       rst,
  input  logic       game_start_end,
  input  logic       turn_up,
  input  logic       turn_down,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       move_tick,
  output logic [1:0] dir,
  output logic       pending_valid,
  output logic       turn_pulse,
  output logic       reject_pulse
);

  localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

  // Button index equals the direction code it requests.
  logic [3:0]  raw;
  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  db_q, db_d, db_prev_q;
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [3:0]  press;

  assign raw = {turn_right, turn_left, turn_down, turn_up};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LIMIT) db_d[i] = ~db_q[i];
        else                      cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press = db_q & ~db_prev_q;

  logic [1:0] dir_q, dir_d, pend_q, pend_d;
  logic       pv_q, pv_d, turn_q, turn_d, rej_q, rej_d;
  logic       win_vld, opposite, legal;
  logic [1:0] win_dir;

  always_comb begin
    win_vld = |press;
    win_dir = 2'b00;
    if      (press[0]) win_dir = 2'b00;
    else if (press[1]) win_dir = 2'b01;
    else if (press[2]) win_dir = 2'b10;
    else if (press[3]) win_dir = 2'b11;
    // Reversal flips only the low bit: up<->down, left<->right.
    opposite = win_vld && (win_dir == {dir_q[1], ~dir_q[0]});
    legal    = win_vld && (win_dir != dir_q) && !opposite;
  end

  always_comb begin
    dir_d  = dir_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    turn_d = 1'b0;
    rej_d  = 1'b0;
    if (rst) begin
      dir_d = DIR_INIT;
      pv_d  = 1'b0;
    end else if (!game_start_end) begin
      pv_d = 1'b0;
    end else begin
      rej_d = opposite;
      if (move_tick && (legal || pv_q)) begin
        dir_d  = legal ? win_dir : pend_q;
        pv_d   = 1'b0;
        turn_d = 1'b1;
      end else if (!move_tick && legal) begin
        pend_d = win_dir;
        pv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dir_q  <= DIR_INIT;
      pend_q <= DIR_INIT;
      pv_q   <= 1'b0;
      turn_q <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      turn_q <= turn_d;
      rej_q  <= rej_d;
    end
  end

  assign dir           = dir_q;
  assign pending_valid = pv_q;
  assign turn_pulse    = turn_q;
  assign reject_pulse  = rej_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: per-cycle expected outputs are queued
// by the stimulus driver and compared on the falling clock edge.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       clrn, rst, game_start_end;
  logic       turn_up, turn_down, turn_left, turn_right, move_tick;
  logic [1:0] dir;
  logic       pending_valid, turn_pulse, reject_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [1:0] d;
    logic       pv;
    logic       tp;
    logic       rj;
  } exp_t;
  exp_t sb[$];

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .DIR_INIT(2'b00)) dut (
    .clk(clk), .clrn(clrn), .rst(rst), .game_start_end(game_start_end),
    .turn_up(turn_up), .turn_down(turn_down), .turn_left(turn_left),
    .turn_right(turn_right), .move_tick(move_tick), .dir(dir),
    .pending_valid(pending_valid), .turn_pulse(turn_pulse),
    .reject_pulse(reject_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic exp_rng(input int a, input int b, input logic [1:0] d,
                         input logic pv, input logic tp, input logic rj);
    for (int c = a; c <= b; c++) begin
      exp_t e;
      e.cyc = c; e.d = d; e.pv = pv; e.tp = tp; e.rj = rj;
      sb.push_back(e);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) check_eq("sb_late", e.cyc, cyc);
      else begin
        check_eq("dir",           int'(dir),           int'(e.d));
        check_eq("pending_valid", int'(pending_valid), int'(e.pv));
        check_eq("turn_pulse",    int'(turn_pulse),    int'(e.tp));
        check_eq("reject_pulse",  int'(reject_pulse),  int'(e.rj));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0; rst = 1'b0; game_start_end = 1'b1; move_tick = 1'b0;
    turn_up = 1'b1; turn_down = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
    // Up held through reset release: press equals dir, nothing visible.
    exp_rng(1, 40, 2'b00, 0, 0, 0);
    wait_n(10); clrn = 1'b1;
    wait_n(20); turn_up = 1'b0;
    wait_n(10);

    // Left press -> pending at sample+7, then committed on move_tick.
    exp_rng(41, 47, 2'b00, 0, 0, 0);
    exp_rng(48, 52, 2'b00, 1, 0, 0);
    exp_rng(53, 53, 2'b10, 0, 1, 0);
    exp_rng(54, 72, 2'b10, 0, 0, 0);
    turn_left = 1'b1;
    wait_n(10); turn_left = 1'b0;
    wait_n(2);  move_tick = 1'b1;
    wait_n(1);  move_tick = 1'b0;
    wait_n(19);

    // Reversal right while heading left -> single reject, tick changes nothing.
    exp_rng(73, 79, 2'b10, 0, 0, 0);
    exp_rng(80, 80, 2'b10, 0, 0, 1);
    exp_rng(81, 95, 2'b10, 0, 0, 0);
    turn_right = 1'b1;
    wait_n(8); turn_right = 1'b0;
    wait_n(4); move_tick = 1'b1;
    wait_n(1); move_tick = 1'b0;
    wait_n(10);

    // Bouncing down button never debounces.
    exp_rng(96, 135, 2'b10, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      turn_down = 1'b1; wait_n(2);
      turn_down = 1'b0; wait_n(2);
    end
    wait_n(20);

    // Restart to up, then left+right together: left wins priority.
    exp_rng(136, 143, 2'b00, 0, 0, 0);
    exp_rng(144, 146, 2'b00, 1, 0, 0);
    exp_rng(147, 147, 2'b10, 0, 1, 0);
    exp_rng(148, 160, 2'b10, 0, 0, 0);
    rst = 1'b1;
    wait_n(1); rst = 1'b0; turn_left = 1'b1; turn_right = 1'b1;
    wait_n(8); turn_left = 1'b0; turn_right = 1'b0;
    wait_n(2); move_tick = 1'b1;
    wait_n(1); move_tick = 1'b0;
    wait_n(13);

    // Restart, left queued, later right overwrites it; tick commits right.
    exp_rng(161, 168, 2'b00, 0, 0, 0);
    exp_rng(169, 189, 2'b00, 1, 0, 0);
    exp_rng(190, 190, 2'b11, 0, 1, 0);
    exp_rng(191, 205, 2'b11, 0, 0, 0);
    rst = 1'b1;
    wait_n(1);  rst = 1'b0; turn_left = 1'b1;
    wait_n(8);  turn_left = 1'b0;
    wait_n(10); turn_right = 1'b1;
    wait_n(8);  turn_right = 1'b0;
    wait_n(2);  move_tick = 1'b1;
    wait_n(1);  move_tick = 1'b0;
    wait_n(15);

    // Up queued, then rst with move_tick wins; then halted game ignores all.
    exp_rng(206, 212, 2'b11, 0, 0, 0);
    exp_rng(213, 215, 2'b11, 1, 0, 0);
    exp_rng(216, 260, 2'b00, 0, 0, 0);
    turn_up = 1'b1;
    wait_n(8);  turn_up = 1'b0;
    wait_n(2);  rst = 1'b1; move_tick = 1'b1;
    wait_n(1);  rst = 1'b0; move_tick = 1'b0;
    wait_n(9);  game_start_end = 1'b0; turn_down = 1'b1;
    wait_n(8);  turn_down = 1'b0;
    wait_n(2);  turn_left = 1'b1;
    wait_n(8);  turn_left = 1'b0;
    wait_n(2);  move_tick = 1'b1;
    wait_n(1);  move_tick = 1'b0;
    wait_n(16);

    check_eq("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
